// File: rtl/riscv_core_icache_pkg.sv
// rtl/riscv_core_icache_pkg.sv - shared types and AXI constants for the icache refill path
//
// Contents:
//   state_e          refill FSM state encoding (IDLE, ADDR, DATA, DONE)
//   AXI_BURST_*      AR burst-type encodings
//   AXI_SIZE_8B      AR size encoding for 8-byte beats
//   AXI_RESP_*       R response encodings
//   LINE_BEATS       number of R beats that make up one cache line
package riscv_core_icache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [2:0] AXI_SIZE_8B = 3'b011;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int LINE_WIDTH_DFLT     = 256;
    localparam int AXI_DATA_WIDTH_DFLT = 64;
    localparam int LINE_BEATS          = LINE_WIDTH_DFLT / AXI_DATA_WIDTH_DFLT;

endpackage

// File: rtl/riscv_core_icache_refill_master.sv
// rtl/riscv_core_icache_refill_master.sv - AXI read-burst master that refills one icache line
//
// Ports:
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_req_valid/o_req_ready          refill request handshake
//   i_req_addr                       miss address (any byte alignment)
//   i_flush                          discard the result of the refill in flight
//   o_line_valid                     one-cycle pulse, line delivered
//   o_line_data/o_line_addr          assembled line and its line-aligned address
//   o_line_err                       bus error or protocol violation during the burst
//   o_ar*/i_arready                  AXI read-address channel
//   i_r*/o_rready                    AXI read-data channel
module riscv_core_icache_refill_master
    import riscv_core_icache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int LINE_WIDTH     = 256,
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ID         = 0
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,

    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic                      i_flush,

    output logic                      o_line_valid,
    output logic [LINE_WIDTH-1:0]     o_line_data,
    output logic [ADDR_WIDTH-1:0]     o_line_addr,
    output logic                      o_line_err,

    output logic                      o_arvalid,
    input  logic                      i_arready,
    output logic [ADDR_WIDTH-1:0]     o_araddr,
    output logic [7:0]                o_arlen,
    output logic [2:0]                o_arsize,
    output logic [1:0]                o_arburst,
    output logic [ID_WIDTH-1:0]       o_arid,

    input  logic                      i_rvalid,
    output logic                      o_rready,
    input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
    input  logic [1:0]                i_rresp,
    input  logic                      i_rlast,
    input  logic [ID_WIDTH-1:0]       i_rid
);

    localparam int                    LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK  = ~ADDR_WIDTH'(LINE_BYTES - 1);

    generate
        if (LINE_WIDTH / AXI_DATA_WIDTH != LINE_BEATS) begin : g_bad_line_cfg
            $error("LINE_WIDTH/AXI_DATA_WIDTH must equal LINE_BEATS");
        end
    endgenerate

    state_e                  state_q;
    logic [1:0]              beat_q;
    logic                    flush_q;
    logic                    err_q;
    logic [LINE_WIDTH-1:0]   line_q;
    logic [ADDR_WIDTH-1:0]   addr_q;

    logic                    beat_last_d;
    logic                    beat_err_d;

    // A beat is bad if the slave flags an error, the ID is foreign, or
    // rlast disagrees with our own beat count (early or missing last).
    always_comb begin
        beat_last_d = (beat_q == 2'(LINE_BEATS - 1));
        beat_err_d  = (i_rresp == AXI_RESP_SLVERR) || (i_rresp == AXI_RESP_DECERR) ||
                      (i_rid != ID_WIDTH'(AXI_ID)) || (i_rlast != beat_last_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            flush_q <= 1'b0;
            err_q   <= 1'b0;
            line_q  <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        state_q <= ST_ADDR;
                        addr_q  <= i_req_addr & LINE_MASK;
                        beat_q  <= '0;
                        line_q  <= '0;
                        err_q   <= 1'b0;
                        flush_q <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    // The AR request is never withdrawn; a flush only poisons the result.
                    flush_q <= flush_q | i_flush;
                    if (i_arready) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    flush_q <= flush_q | i_flush;
                    if (i_rvalid) begin
                        line_q[int'(beat_q) * AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
                        beat_q <= beat_q + 2'd1;
                        if (beat_err_d) begin
                            err_q <= 1'b1;
                        end
                        // An early rlast ends the burst; untouched slots keep their cleared value.
                        if (beat_last_d || i_rlast) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_req_ready  = (state_q == ST_IDLE);
    assign o_arvalid    = (state_q == ST_ADDR);
    assign o_rready     = (state_q == ST_DATA);
    // A flush arriving in the DONE cycle itself still kills the pulse.
    assign o_line_valid = (state_q == ST_DONE) && !flush_q && !i_flush;

    assign o_araddr     = addr_q;
    assign o_arlen      = 8'(LINE_BEATS - 1);
    assign o_arsize     = AXI_SIZE_8B;
    assign o_arburst    = AXI_BURST_INCR;
    assign o_arid       = ID_WIDTH'(AXI_ID);

    assign o_line_data  = line_q;
    assign o_line_addr  = addr_q;
    assign o_line_err   = err_q;

endmodule

// File: tb/tb_riscv_core_icache_refill_master.sv
// tb/tb_riscv_core_icache_refill_master.sv - directed scoreboard bench for the icache refill master
module tb_riscv_core_icache_refill_master;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int LW = 256;
    localparam int IW = 4;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_req_valid = 1'b0;
    logic            o_req_ready;
    logic [AW-1:0]   i_req_addr = '0;
    logic            i_flush = 1'b0;
    logic            o_line_valid;
    logic [LW-1:0]   o_line_data;
    logic [AW-1:0]   o_line_addr;
    logic            o_line_err;
    logic            o_arvalid;
    logic            i_arready = 1'b0;
    logic [AW-1:0]   o_araddr;
    logic [7:0]      o_arlen;
    logic [2:0]      o_arsize;
    logic [1:0]      o_arburst;
    logic [IW-1:0]   o_arid;
    logic            i_rvalid = 1'b0;
    logic            o_rready;
    logic [DW-1:0]   i_rdata = '0;
    logic [1:0]      i_rresp = '0;
    logic            i_rlast = 1'b0;
    logic [IW-1:0]   i_rid = '0;

    riscv_core_icache_refill_master #(
        .ADDR_WIDTH     (AW),
        .AXI_DATA_WIDTH (DW),
        .LINE_WIDTH     (LW),
        .ID_WIDTH       (IW),
        .AXI_ID         (0)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_flush      (i_flush),
        .o_line_valid (o_line_valid),
        .o_line_data  (o_line_data),
        .o_line_addr  (o_line_addr),
        .o_line_err   (o_line_err),
        .o_arvalid    (o_arvalid),
        .i_arready    (i_arready),
        .o_araddr     (o_araddr),
        .o_arlen      (o_arlen),
        .o_arsize     (o_arsize),
        .o_arburst    (o_arburst),
        .o_arid       (o_arid),
        .i_rvalid     (i_rvalid),
        .o_rready     (o_rready),
        .i_rdata      (i_rdata),
        .i_rresp      (i_rresp),
        .i_rlast      (i_rlast),
        .i_rid        (i_rid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [LW-1:0] data;
        logic [AW-1:0] addr;
        logic          err;
        int            lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   pulses = 0;
    int   exp_pulses = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every delivered line is popped and compared.
    always @(negedge i_clk) begin
        if (i_rst_n && o_line_valid) begin
            pulses++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_line_valid observed=%0d queued expected>0", sb.size());
            end
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("line_data", 320'(o_line_data), 320'(mon_e.data));
                check("line_addr", 320'(o_line_addr), 320'(mon_e.addr));
                check("line_err",  320'(o_line_err),  320'(mon_e.err));
                check("latency",   320'(cyc - acc_cyc + 1), 320'(mon_e.lat));
            end
        end
    end

    task automatic push_exp(input logic [LW-1:0] data, input logic [AW-1:0] addr,
                            input logic err, input int lat);
        exp_t e;
        e.data = data;
        e.addr = addr;
        e.err  = err;
        e.lat  = lat;
        sb.push_back(e);
        exp_pulses++;
    endtask

    task automatic do_req(input logic [AW-1:0] addr);
        check("req_ready_idle", 320'(o_req_ready), 320'(1'b1));
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        @(negedge i_clk);
        acc_cyc     = cyc;
        i_req_valid = 1'b0;
    endtask

    task automatic ar_phase(input int stall, input logic [AW-1:0] exp_addr);
        for (int i = 0; i < stall; i++) begin
            check("ar_stable", 320'({o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid}),
                  320'({1'b1, exp_addr, 8'd3, 3'b011, 2'b01, 4'd0}));
            @(negedge i_clk);
        end
        check("ar_fields", 320'({o_arvalid, o_araddr, o_arlen, o_arsize, o_arburst, o_arid}),
              320'({1'b1, exp_addr, 8'd3, 3'b011, 2'b01, 4'd0}));
        i_arready = 1'b1;
        @(negedge i_clk);
        i_arready = 1'b0;
    endtask

    task automatic beat(input int gap, input logic [DW-1:0] data, input logic [1:0] resp,
                        input logic last);
        for (int i = 0; i < gap; i++) begin
            @(negedge i_clk);
        end
        check("rready_beat", 320'(o_rready), 320'(1'b1));
        i_rvalid = 1'b1;
        i_rdata  = data;
        i_rresp  = resp;
        i_rlast  = last;
        i_rid    = '0;
        @(negedge i_clk);
        i_rvalid = 1'b0;
        i_rlast  = 1'b0;
        i_rresp  = '0;
    endtask

    localparam logic [DW-1:0] D1 = 64'h1111_1111_1111_1111;
    localparam logic [DW-1:0] D2 = 64'h2222_2222_2222_2222;
    localparam logic [DW-1:0] D3 = 64'h3333_3333_3333_3333;
    localparam logic [DW-1:0] D4 = 64'h4444_4444_4444_4444;

    initial begin
        // Reset state
        #12;
        check("rst_ctrl", 320'({o_arvalid, o_rready, o_line_valid, o_line_err}), 320'(4'b0000));
        check("rst_line_data", 320'(o_line_data), 320'(0));
        check("rst_line_addr", 320'(o_line_addr), 320'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", 320'(o_req_ready), 320'(1'b1));

        // Basic refill, no stalls
        push_exp({D4, D3, D2, D1}, 64'h8000_1220, 1'b0, 6);
        do_req(64'h0000_0000_8000_1234);
        ar_phase(0, 64'h8000_1220);
        beat(0, D1, 2'b00, 1'b0);
        beat(0, D2, 2'b00, 1'b0);
        beat(0, D3, 2'b00, 1'b0);
        beat(0, D4, 2'b00, 1'b1);
        check("rready_done", 320'(o_rready), 320'(1'b0));
        @(negedge i_clk);
        check("single_pulse", 320'(o_line_valid), 320'(1'b0));
        check("line_hold", 320'(o_line_data), 320'({D4, D3, D2, D1}));
        check("ready_after_done", 320'(o_req_ready), 320'(1'b1));

        // AR stalled 5 cycles, 2-cycle gaps between R beats
        push_exp({64'hDDDD_0004_0000_0003, 64'hCCCC_0003_0000_0002,
                  64'hBBBB_0002_0000_0001, 64'hAAAA_0001_0000_0000},
                 64'h0000_0000_1234_5660, 1'b0, 17);
        do_req(64'h0000_0000_1234_567F);
        ar_phase(5, 64'h0000_0000_1234_5660);
        beat(0, 64'hAAAA_0001_0000_0000, 2'b00, 1'b0);
        beat(2, 64'hBBBB_0002_0000_0001, 2'b00, 1'b0);
        beat(2, 64'hCCCC_0003_0000_0002, 2'b00, 1'b0);
        beat(2, 64'hDDDD_0004_0000_0003, 2'b00, 1'b1);
        @(negedge i_clk);

        // SLVERR on beat 1: all four beats consumed, error reported
        push_exp({D1, D2, D3, D4}, 64'h0000_0000_0000_0040, 1'b1, 6);
        do_req(64'h0000_0000_0000_0048);
        ar_phase(0, 64'h0000_0000_0000_0040);
        beat(0, D4, 2'b00, 1'b0);
        beat(0, D3, 2'b10, 1'b0);
        beat(0, D2, 2'b00, 1'b0);
        beat(0, D1, 2'b00, 1'b1);
        @(negedge i_clk);

        // Early rlast on beat 1: short line, slots 2-3 zero
        push_exp({64'h0, 64'h0, D3, D2}, 64'hFFFF_FFFF_FFFF_FFE0, 1'b1, 4);
        do_req(64'hFFFF_FFFF_FFFF_FFE5);
        ar_phase(0, 64'hFFFF_FFFF_FFFF_FFE0);
        beat(0, D2, 2'b00, 1'b0);
        beat(0, D3, 2'b00, 1'b1);
        check("rready_early_done", 320'(o_rready), 320'(1'b0));
        @(negedge i_clk);

        // Flush during beat 2: burst drained, no line delivered
        do_req(64'h0000_0000_0000_2000);
        ar_phase(0, 64'h0000_0000_0000_2000);
        beat(0, D1, 2'b00, 1'b0);
        beat(0, D2, 2'b00, 1'b0);
        i_flush = 1'b1;
        beat(0, D3, 2'b00, 1'b0);
        i_flush = 1'b0;
        beat(0, D4, 2'b00, 1'b1);
        check("flush_no_valid", 320'(o_line_valid), 320'(1'b0));
        check("flush_busy", 320'(o_req_ready), 320'(1'b0));
        @(negedge i_clk);
        check("flush_ready_next", 320'(o_req_ready), 320'(1'b1));

        // Reset asserted while beat 1 is on the bus
        do_req(64'h0000_0000_0000_3008);
        ar_phase(0, 64'h0000_0000_0000_3000);
        beat(0, D1, 2'b00, 1'b0);
        i_rvalid = 1'b1;
        i_rdata  = D2;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_ctrl", 320'({o_arvalid, o_rready, o_line_valid, o_line_err}), 320'(4'b0000));
        check("arst_line_data", 320'(o_line_data), 320'(0));
        check("arst_line_addr", 320'(o_line_addr), 320'(0));
        @(negedge i_clk);
        i_rvalid = 1'b0;
        i_rst_n  = 1'b1;
        @(negedge i_clk);
        check("ready_after_arst", 320'(o_req_ready), 320'(1'b1));

        // Full refill after the mid-burst reset
        push_exp({D1, D4, D3, D2}, 64'h0000_0000_8000_1220, 1'b0, 6);
        do_req(64'h0000_0000_8000_123F);
        ar_phase(0, 64'h0000_0000_8000_1220);
        beat(0, D2, 2'b00, 1'b0);
        beat(0, D3, 2'b00, 1'b0);
        beat(0, D4, 2'b00, 1'b0);
        beat(0, D1, 2'b00, 1'b1);
        repeat (3) @(negedge i_clk);

        check("sb_drained", 320'(sb.size()), 320'(0));
        check("pulse_count", 320'(pulses), 320'(exp_pulses));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
